// File: rtl/slowclk_bank.sv
// slowclk_bank: a bank of independent programmable clock dividers.
// Each channel produces a one-cycle tick every N enabled cycles and a
// 50 % square wave. Divisor writes take effect only at a period
// boundary, so no channel ever emits a runt period. A global sync
// restarts and phase-aligns every channel.
module slowclk_bank #(
  parameter  int CHANNELS    = 4,
  parameter  int WIDTH       = 28,
  parameter  int DEFAULT_DIV = 1,
  localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] en,
  input  logic                sync,
  input  logic                load,
  input  logic [CH_W-1:0]     load_ch,
  input  logic [WIDTH-1:0]    load_div,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] slowclk,
  output logic [CHANNELS-1:0] div_pending
);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : ch_g
      logic [WIDTH-1:0] n_q, n_d;      // active divisor
      logic [WIDTH-1:0] p_q, p_d;      // divisor waiting for a period boundary
      logic [WIDTH-1:0] c_q, c_d;      // cycle counter within the period
      logic             pend_q, pend_d;
      logic             tick_q, tick_d;
      logic             slow_q, slow_d;
      logic             wr;
      logic             tc;

      // An index that matches no channel (load_ch >= CHANNELS) selects nothing.
      assign wr = load && (load_ch == CH_W'(gi));
      // Terminal count: the last enabled cycle of the current period.
      assign tc = en[gi] && (n_q != '0) && (c_q == n_q - WIDTH'(1));

      // Next-state logic: sync, then halted channel, then terminal count, then counting.
      always_comb begin
        n_d    = n_q;
        p_d    = p_q;
        c_d    = c_q;
        pend_d = pend_q;
        slow_d = slow_q;
        tick_d = 1'b0;
        if (sync) begin
          // Restart: drop the partial count; any queued or same-cycle
          // write becomes active immediately.
          c_d    = '0;
          slow_d = 1'b0;
          pend_d = 1'b0;
          if (wr)          n_d = load_div;
          else if (pend_q) n_d = p_q;
        end else if (n_q == '0) begin
          // Halted channel has no period to finish, so a queued divisor
          // activates on the very next edge.
          c_d = '0;
          if (wr) begin
            p_d    = load_div;
            pend_d = 1'b1;
          end else if (pend_q) begin
            n_d    = p_q;
            pend_d = 1'b0;
          end
        end else if (tc) begin
          // Period boundary: emit the tick and swap in a new divisor. A
          // write landing on this edge skips the pending stage.
          c_d    = '0;
          tick_d = 1'b1;
          slow_d = ~slow_q;
          pend_d = 1'b0;
          if (wr)          n_d = load_div;
          else if (pend_q) n_d = p_q;
        end else begin
          if (en[gi]) c_d = c_q + WIDTH'(1);
          if (wr) begin
            p_d    = load_div;
            pend_d = 1'b1;
          end
        end
      end

      // Channel state registers with synchronous active-low reset.
      always_ff @(posedge clk) begin
        if (!reset) begin
          n_q    <= WIDTH'(DEFAULT_DIV);
          p_q    <= '0;
          c_q    <= '0;
          pend_q <= 1'b0;
          tick_q <= 1'b0;
          slow_q <= 1'b0;
        end else begin
          n_q    <= n_d;
          p_q    <= p_d;
          c_q    <= c_d;
          pend_q <= pend_d;
          tick_q <= tick_d;
          slow_q <= slow_d;
        end
      end

      assign tick[gi]        = tick_q;
      assign slowclk[gi]     = slow_q;
      assign div_pending[gi] = pend_q;
    end
  endgenerate

endmodule
